// File: rtl/cpu_pkg.sv
// Shared CPU constants: default datapath/register-index widths and the write-back source select encoding.
package cpu_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    localparam logic WB_SEL_ALU = 1'b1;
    localparam logic WB_SEL_MEM = 1'b0;

endpackage : cpu_pkg

// File: rtl/rf_core.sv
// Register-file storage with one write port and two combinational read ports.
// Index 0 is hardwired to zero.
module rf_core
    import cpu_pkg::*;
#(
    parameter int DATA_W_P = DATA_W,
    parameter int ADDR_W_P = ADDR_W
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    input  logic                we_i,
    input  logic [ADDR_W_P-1:0] waddr_i,
    input  logic [DATA_W_P-1:0] wdata_i,
    input  logic [ADDR_W_P-1:0] raddr_a_i,
    input  logic [ADDR_W_P-1:0] raddr_b_i,
    output logic [DATA_W_P-1:0] rdata_a_o,
    output logic [DATA_W_P-1:0] rdata_b_o
);

    localparam int DEPTH = 2 ** ADDR_W_P;

    logic [DATA_W_P-1:0] regs_q [DEPTH];

    // NOTE: the whole array is cleared on reset, so it maps to flops rather than a RAM macro;
    // a register file must come out of reset with known contents.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            regs_q <= '{default: '0};
        end else if (we_i && (waddr_i != '0)) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_a_o = (raddr_a_i == '0) ? '0 : regs_q[raddr_a_i];
    assign rdata_b_o = (raddr_b_i == '0) ? '0 : regs_q[raddr_b_i];

endmodule : rf_core

// File: rtl/wb_regfile.sv
// Write-back stage register file: source mux, write qualifier, retired-write counter.
// Define WB_BYPASS_EN to make same-cycle reads of the written index return the write-back value.
module wb_regfile
    import cpu_pkg::*;
#(
    parameter int DATA_W_P = DATA_W,
    parameter int ADDR_W_P = ADDR_W
) (
    input  logic                Clk,
    input  logic                Clrn,
    input  logic                wWreg,
    input  logic                wReg2reg,
    input  logic [DATA_W_P-1:0] wD,
    input  logic [DATA_W_P-1:0] wC,
    input  logic [ADDR_W_P-1:0] wRd,
    input  logic [ADDR_W_P-1:0] Rs,
    input  logic [ADDR_W_P-1:0] Rt,
    output logic [DATA_W_P-1:0] Qa,
    output logic [DATA_W_P-1:0] Qb,
    output logic [DATA_W_P-1:0] WbData,
    output logic [31:0]         WbCount
);

    logic                wr_qual;
    logic [DATA_W_P-1:0] core_qa;
    logic [DATA_W_P-1:0] core_qb;
    logic [31:0]         wb_count_q;
    logic [31:0]         wb_count_d;

    assign WbData  = (wReg2reg == WB_SEL_ALU) ? wC : wD;
    // Reset and index 0 both veto the write, which also keeps them out of the counter and bypass.
    assign wr_qual = wWreg && (wRd != '0) && Clrn;

    rf_core #(
        .DATA_W_P (DATA_W_P),
        .ADDR_W_P (ADDR_W_P)
    ) u_rf_core (
        .clk_i     (Clk),
        .rst_n_i   (Clrn),
        .we_i      (wr_qual),
        .waddr_i   (wRd),
        .wdata_i   (WbData),
        .raddr_a_i (Rs),
        .raddr_b_i (Rt),
        .rdata_a_o (core_qa),
        .rdata_b_o (core_qb)
    );

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        wb_count_d = wb_count_q;
        if (wr_qual) begin
            wb_count_d = wb_count_q + 32'd1;
        end
    end

    always_ff @(posedge Clk) begin
        if (!Clrn) begin
            wb_count_q <= '0;
        end else begin
            wb_count_q <= wb_count_d;
        end
    end

    assign WbCount = wb_count_q;

`ifdef WB_BYPASS_EN
    assign Qa = (wr_qual && (Rs == wRd)) ? WbData : core_qa;
    assign Qb = (wr_qual && (Rt == wRd)) ? WbData : core_qb;
`else
    assign Qa = core_qa;
    assign Qb = core_qb;
`endif

endmodule : wb_regfile

// File: doc/wb_regfile.md
WB_REGFILE -- requirements
Module: wb_regfile

Interface
REQ-001 Parameter DATA_W, default 32, register and datapath width in bits.
REQ-002 Parameter ADDR_W, default 5, register index width; depth is 2**ADDR_W.
REQ-003 Clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 Clrn  input  1  reset; synchronous, active-low.
REQ-005 wWreg  input  1  write-back enable from the MEM/WB register.
REQ-006 wReg2reg  input  1  write-back source select: 1 = ALU result wC, 0 = memory data wD.
REQ-007 wD  input  DATA_W  memory load data from the MEM/WB register.
REQ-008 wC  input  DATA_W  ALU result from the MEM/WB register.
REQ-009 wRd  input  ADDR_W  destination register index.
REQ-010 Rs, Rt  input  ADDR_W  decode-stage read indices, ports A and B.
REQ-011 Qa, Qb  output  DATA_W  read data for Rs and Rt.
REQ-012 WbData  output  DATA_W  selected write-back value, combinational.
REQ-013 WbCount  output  32  count of retired register writes.

Function
REQ-014 WbData SHALL equal wC when wReg2reg=1, else wD, with zero latency.
REQ-015 Write qualifier SHALL be wWreg=1 AND wRd!=0 AND Clrn=1; when true, reg[wRd] SHALL take WbData at the rising edge of Clk.
REQ-016 Register 0 SHALL read 0 at all times; writes to index 0 SHALL be discarded and not counted.
REQ-017 Qa/Qb SHALL be combinational reads of reg[Rs]/reg[Rt]; Rs=Rt SHALL return identical data on both ports.
REQ-018 WbCount SHALL increment by 1 on each rising edge where the write qualifier is true.
REQ-019 WbCount SHALL wrap from 0xFFFFFFFF to 0x00000000 with no flag.
REQ-020 Unqualified cycles (wWreg=0 or wRd=0) SHALL leave every register and WbCount unchanged.

Reset
REQ-021 With Clrn=0 at a rising edge, registers 1..2**ADDR_W-1 and WbCount SHALL become 0.
REQ-022 A write presented in the same cycle as Clrn=0 SHALL be dropped; reset wins.
REQ-023 Reset SHALL be honoured mid-stream; the first write after Clrn returns high SHALL land normally and bring WbCount to 1.

Configuration
REQ-024 Macro WB_BYPASS_EN defined: when the write qualifier is true and Rs (or Rt) equals wRd, Qa (or Qb) SHALL return WbData in the same cycle (write-through).
REQ-025 WB_BYPASS_EN undefined: Qa/Qb SHALL return the pre-write stored value in that cycle and the new value from the next cycle on; the hazard is left to the forwarding unit.
REQ-026 Bypass SHALL never apply to index 0 or while Clrn=0.

Structure
REQ-027 DATA_W, ADDR_W and the select constants WB_SEL_ALU=1 and WB_SEL_MEM=0 SHALL live in the shared package cpu_pkg.
REQ-028 Storage and the two read ports SHALL be a sub-module rf_core; the write-back mux, qualifier, bypass and counter SHALL sit in wb_regfile.

Verification
REQ-029 Reset: hold Clrn=0 for 1 cycle after random writes -> Qa=Qb=0 for all Rs/Rt and WbCount=0.
REQ-030 Source select: wWreg=1, wRd=5, wC=0x1234_5678, wD=0xDEAD_BEEF, wReg2reg=1 -> next cycle Rs=5 gives Qa=0x1234_5678; repeat with wReg2reg=0 -> 0xDEAD_BEEF; WbCount=2.
REQ-031 Zero register: wWreg=1, wRd=0, wC=0xFFFF_FFFF -> Qa(Rs=0)=0 and WbCount unchanged.
REQ-032 Same-cycle read/write: reg7=0x11, write wC=0x22 to 7 with Rs=Rt=7 -> Qa=Qb=0x22 that cycle with WB_BYPASS_EN, 0x11 without; 0x22 the next cycle in both builds.
REQ-033 Reset collision: Clrn=0 with wWreg=1, wRd=3, wC=0x55 -> reg3=0 and WbCount=0 afterwards.
REQ-034 Counter wrap: force WbCount=0xFFFF_FFFF, perform one qualified write -> WbCount=0.
